// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with load, clear, wrap/saturate and limit pulses
// Limit hits are detected on WIDTH+1 bit sums so MODULUS == 2**WIDTH needs no special case.
module mod_counter #(
   parameter int          WIDTH      = 8,
   parameter int unsigned MODULUS    = 256,
   parameter int unsigned INIT_VALUE = 'hff,
   parameter bit          SATURATE   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             c_up,
   input  logic             c_down,
   output logic [WIDTH-1:0] q,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             udf,
   output logic             err_sticky
);

   localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_V  = MAX_W[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   inc_w;
   logic [WIDTH:0]   dec_w;
   logic [WIDTH:0]   d_ext;
   logic             up_hit;
   logic             down_hit;

   assign q_ext    = {1'b0, q_q};
   assign inc_w    = q_ext + (WIDTH+1)'(1);
   assign dec_w    = q_ext - (WIDTH+1)'(1);
   assign d_ext    = {1'b0, d};
   assign up_hit   = (inc_w == MOD_W);
   // A borrow out of the top bit means q was already 0.
   assign down_hit = dec_w[WIDTH];

   always_comb begin
      q_d   = q_q;
      ovf_d = 1'b0;
      udf_d = 1'b0;
      err_d = err_q;
      if (clear) begin
         q_d   = INIT_V;
         err_d = 1'b0;
      end else if (load) begin
         q_d = (d_ext < MOD_W) ? d : MAX_V;
      end else if (c_up && !c_down) begin
         if (up_hit) begin
            q_d   = SATURATE ? q_q : '0;
            ovf_d = 1'b1;
            err_d = 1'b1;
         end else begin
            q_d = inc_w[WIDTH-1:0];
         end
      end else if (c_down && !c_up) begin
         if (down_hit) begin
            q_d   = SATURATE ? q_q : MAX_V;
            udf_d = 1'b1;
            err_d = 1'b1;
         end else begin
            q_d = dec_w[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_q   <= INIT_V;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         err_q <= err_d;
      end
   end

   assign q          = q_q;
   assign at_max     = (q_ext == MAX_W);
   assign at_min     = (q_q == '0);
   assign ovf        = ovf_q;
   assign udf        = udf_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter in wrap, saturate and full-range configs
module tb_mod_counter;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       clear = 1'b0, load = 1'b0, c_up = 1'b0, c_down = 1'b0;
   logic [7:0] d = '0;

   logic [7:0] q0, q1, q2;
   logic       amx0, amx1, amx2, amn0, amn1, amn2;
   logic       ov0, ov1, ov2, ud0, ud1, ud2, er0, er1, er2;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(8), .MODULUS(10), .INIT_VALUE(9), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_b(rst_b), .clear(clear), .load(load), .d(d), .c_up(c_up), .c_down(c_down),
      .q(q0), .at_max(amx0), .at_min(amn0), .ovf(ov0), .udf(ud0), .err_sticky(er0));
   mod_counter #(.WIDTH(8), .MODULUS(10), .INIT_VALUE(9), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_b(rst_b), .clear(clear), .load(load), .d(d), .c_up(c_up), .c_down(c_down),
      .q(q1), .at_max(amx1), .at_min(amn1), .ovf(ov1), .udf(ud1), .err_sticky(er1));
   mod_counter #(.WIDTH(8), .MODULUS(256), .INIT_VALUE('hff), .SATURATE(1'b0)) u_full (
      .clk(clk), .rst_b(rst_b), .clear(clear), .load(load), .d(d), .c_up(c_up), .c_down(c_down),
      .q(q2), .at_max(amx2), .at_min(amn2), .ovf(ov2), .udf(ud2), .err_sticky(er2));

   typedef struct {
      int inst;
      int q;
      bit ovf, udf, err, amax, amin;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   int   modv [NI] = '{10, 10, 256};
   int   initv[NI] = '{9, 9, 255};
   bit   satv [NI] = '{1'b0, 1'b1, 1'b0};
   int   mq   [NI];
   bit   me   [NI];

   task automatic check(input string name, input int inst, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, inst, got, want, $time);
      end
   endtask

   function automatic void dut_out(input int i, output int oq, output bit ov, output bit ud,
                                   output bit er, output bit amx, output bit amn);
      case (i)
         0:       begin oq = q0; ov = ov0; ud = ud0; er = er0; amx = amx0; amn = amn0; end
         1:       begin oq = q1; ov = ov1; ud = ud1; er = er1; amx = amx1; amn = amn1; end
         default: begin oq = q2; ov = ov2; ud = ud2; er = er2; amx = amx2; amn = amn2; end
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i] = initv[i];
         me[i] = 1'b0;
      end
   endfunction

   // Reference: apply one edge of the priority rules with plain integer arithmetic.
   function automatic exp_t model_edge(input int i, input bit cl, input bit ld, input int dv,
                                       input bit up, input bit dn);
      exp_t e;
      int   m = modv[i];
      e.inst = i; e.ovf = 0; e.udf = 0;
      if (cl) begin
         mq[i] = initv[i];
         me[i] = 0;
      end else if (ld) begin
         mq[i] = (dv < m) ? dv : m - 1;
      end else if (up && !dn) begin
         if (mq[i] == m - 1) begin e.ovf = 1; me[i] = 1; end
         mq[i] = satv[i] ? ((mq[i] + 1 > m - 1) ? m - 1 : mq[i] + 1) : (mq[i] + 1) % m;
      end else if (dn && !up) begin
         if (mq[i] == 0) begin e.udf = 1; me[i] = 1; end
         mq[i] = satv[i] ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1) : (mq[i] - 1 + m) % m;
      end
      e.q    = mq[i];
      e.err  = me[i];
      e.amax = (mq[i] == m - 1);
      e.amin = (mq[i] == 0);
      return e;
   endfunction

   task automatic step(input bit cl, input bit ld, input int dv, input bit up, input bit dn);
      clear = cl; load = ld; d = 8'(dv); c_up = up; c_down = dn;
      for (int i = 0; i < NI; i++) exp_q.push_back(model_edge(i, cl, ld, dv, up, dn));
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_state(input string tag);
      int oq; bit ov, ud, er, amx, amn;
      for (int i = 0; i < NI; i++) begin
         dut_out(i, oq, ov, ud, er, amx, amn);
         check({tag, "_q"}, i, oq, initv[i]);
         check({tag, "_ovf"}, i, int'(ov), 0);
         check({tag, "_udf"}, i, int'(ud), 0);
         check({tag, "_err"}, i, int'(er), 0);
      end
   endtask

   initial begin : monitor
      exp_t e;
      int oq; bit ov, ud, er, amx, amn;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dut_out(e.inst, oq, ov, ud, er, amx, amn);
            check("q", e.inst, oq, e.q);
            check("ovf", e.inst, int'(ov), int'(e.ovf));
            check("udf", e.inst, int'(ud), int'(e.udf));
            check("err_sticky", e.inst, int'(er), int'(e.err));
            check("at_max", e.inst, int'(amx), int'(e.amax));
            check("at_min", e.inst, int'(amn), int'(e.amin));
            check("ovf_udf_excl", e.inst, int'(ov && ud), 0);
         end
      end
   end

   initial begin : stim
      int r;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_reset_state("reset");
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #2;
      exp_q.delete();

      // wrap from 9: 0 with ovf, 1, 2; saturate holds at 9 with ovf each cycle
      repeat (3) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      // load out of range clamps to MODULUS-1, then count down through zero
      step(0, 1, 'h0c, 0, 0);
      repeat (10) step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 1);
      // clear beats load and count, then both enables hold
      step(1, 1, 3, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 1, 255, 0, 0);
      step(0, 0, 0, 1, 0);

      // asynchronous reset between edges aborts the count
      step(0, 0, 0, 1, 0);
      rst_b = 1'b0;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;
      step(0, 0, 0, 1, 0);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         step(r < 5, (r >= 5) && (r < 17), int'($urandom_range(0, 255)),
              1'($urandom), 1'($urandom));
      end
      step(0, 0, 0, 0, 0);

      #10;
      check("queue_drained", 0, exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 256, giving the count range 0..MODULUS-1; legal range is 2..2**WIDTH.
REQ-003 The block SHALL have parameter INIT_VALUE, default 8'hff, giving the reset/clear value; legal range is 0..MODULUS-1.
REQ-004 The block SHALL have parameter SATURATE, default 0: 0 selects wrap mode, 1 selects saturate mode.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-006 rst_b  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous return to INIT_VALUE.
REQ-008 load  input  1  synchronous load of d.
REQ-009 d  input  WIDTH  load value.
REQ-010 c_up  input  1  count-up enable.
REQ-011 c_down  input  1  count-down enable.
REQ-012 q  output  WIDTH  registered count value.
REQ-013 at_max  output  1  combinational; high when q == MODULUS-1.
REQ-014 at_min  output  1  combinational; high when q == 0.
REQ-015 ovf  output  1  registered single-cycle pulse marking an up-count attempted at MODULUS-1.
REQ-016 udf  output  1  registered single-cycle pulse marking a down-count attempted at 0.
REQ-017 err_sticky  output  1  registered; set by any ovf/udf event, cleared only by clear or reset.

Function
REQ-018 Per-edge priority SHALL be clear > load > count > hold.
REQ-019 clear=1: q <= INIT_VALUE, err_sticky <= 0, ovf/udf <= 0, regardless of the other inputs.
REQ-020 load=1 (clear=0): q <= d if d < MODULUS, else q <= MODULUS-1; ovf/udf <= 0; err_sticky unchanged.
REQ-021 c_up=1 and c_down=1 together (no clear/load): q holds; ovf/udf <= 0.
REQ-022 Up-count only (c_up=1, c_down=0): q <= q+1 when q < MODULUS-1.
REQ-023 Up-count at q == MODULUS-1: wrap mode q <= 0; saturate mode q holds; in both modes ovf <= 1 and err_sticky <= 1.
REQ-024 Down-count only (c_down=1, c_up=0): q <= q-1 when q > 0.
REQ-025 Down-count at q == 0: wrap mode q <= MODULUS-1; saturate mode q holds; in both modes udf <= 1 and err_sticky <= 1.
REQ-026 ovf and udf SHALL be high for exactly the one cycle following the triggering edge, and SHALL never be high together.
REQ-027 Repeated attempts at a limit in saturate mode SHALL produce one ovf/udf pulse per attempting cycle.
REQ-028 With no clear, load, c_up or c_down: q and err_sticky hold; ovf/udf <= 0.
REQ-029 Count latency SHALL be one cycle: q updates on the edge that samples the enable.
REQ-030 Arithmetic SHALL be WIDTH+1 bits internally, so MODULUS == 2**WIDTH wraps correctly with no truncation hazard.
REQ-031 at_max/at_min SHALL be derived from q only, never from inputs.

Reset
REQ-032 rst_b low SHALL immediately, without waiting for a clock edge, force q = INIT_VALUE and ovf = udf = err_sticky = 0.
REQ-033 rst_b low asserted mid-count SHALL abort the count; the first edge after rst_b rises SHALL be evaluated under normal priority.

Verification (WIDTH=8, MODULUS=10, INIT_VALUE=9 unless stated)
REQ-034 Reset then c_up=1 for 3 cycles, SATURATE=0 -> q: 9,0,1,2; ovf high only in the cycle q=0; err_sticky=1 thereafter.
REQ-035 SATURATE=1, q=9, c_up=1 for 3 cycles -> q stays 9; ovf high 3 consecutive cycles; at_max=1.
REQ-036 load=1 with d=8'h0c -> q=9; then c_down=1 for 10 cycles, SATURATE=0 -> q reaches 0, then 9; udf pulses once.
REQ-037 clear=1, load=1, c_up=1 in the same cycle with err_sticky=1 -> q=9, err_sticky=0; then c_up=c_down=1 -> q holds.
REQ-038 MODULUS=256, INIT_VALUE=8'hff, c_up=1 -> q=8'h00 with ovf; rst_b pulsed low between edges -> q=8'hff asynchronously.
